// File: rtl/pipelined_adder.sv
`timescale 1ns/1ps
`default_nettype none
// pipelined_adder (rev 1.0): WIDTH-bit add/sub split into WIDTH/SEG registered ripple segments, valid/ready handshake.
// Optional build macro PIPELINED_ADDER_SAT_EN adds a 'sat' input that clamps signed-overflowed results.
module pipelined_adder #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
`ifdef PIPELINED_ADDER_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / SEG;
  localparam int LAST   = STAGES - 1;
  localparam int MSB    = WIDTH - 1;
  localparam int PIPE   = (STAGES > 1) ? STAGES - 1 : 1;

  if (SEG < 1 || (WIDTH % SEG) != 0) begin : g_bad_params
    $error("pipelined_adder: WIDTH (%0d) must be a positive multiple of SEG (%0d)", WIDTH, SEG);
  end

  logic [STAGES-1:0]            valid_q, valid_d;
  logic [STAGES-1:0]            carry_q, carry_d;
  logic [STAGES-1:0][WIDTH-1:0] sum_q, sum_d;
  logic [PIPE-1:0][WIDTH-1:0]   a_q, a_d;
  logic [PIPE-1:0][WIDTH-1:0]   b_q, b_d;
  logic                         ovf_q, ovf_d;
`ifdef PIPELINED_ADDER_SAT_EN
  logic [PIPE-1:0]              sat_q, sat_d;
`endif
  logic                         adv;

  assign out_valid = valid_q[LAST];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign s         = sum_q[LAST];
  assign cout      = carry_q[LAST];
  assign ovf       = ovf_q;

  always_comb begin
    logic [STAGES-1:0][WIDTH-1:0] src_a, src_b, src_s;
    logic [STAGES-1:0]            src_c, src_v;
    logic [SEG-1:0]               seg_s;
    logic                         seg_c;
    logic [WIDTH-1:0]             raw_s;
`ifdef PIPELINED_ADDER_SAT_EN
    logic [STAGES-1:0]            src_sat;
    logic [WIDTH-1:0]             smin;
    src_sat    = '0;
    src_sat[0] = sat;
`endif
    src_a    = '0;
    src_b    = '0;
    src_s    = '0;
    src_c    = '0;
    src_v    = '0;
    src_a[0] = a;
    src_b[0] = sub ? ~b : b;
    src_c[0] = cin ^ sub;
    src_v[0] = in_valid;
    // Stage k>0 sees the registers of stage k-1.
    for (int k = 1; k < STAGES; k++) begin
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
      src_s[k] = sum_q[k-1];
      src_c[k] = carry_q[k-1];
      src_v[k] = valid_q[k-1];
`ifdef PIPELINED_ADDER_SAT_EN
      src_sat[k] = sat_q[k-1];
`endif
    end

    seg_s   = '0;
    seg_c   = 1'b0;
    sum_d   = '0;
    carry_d = '0;
    valid_d = '0;
    for (int k = 0; k < STAGES; k++) begin
      {seg_c, seg_s} = {1'b0, src_a[k][k*SEG +: SEG]} + {1'b0, src_b[k][k*SEG +: SEG]}
                     + {{SEG{1'b0}}, src_c[k]};
      sum_d[k]                = src_s[k];
      sum_d[k][k*SEG +: SEG]  = seg_s;
      carry_d[k]              = seg_c;
      valid_d[k]              = src_v[k];
    end

    a_d = '0;
    b_d = '0;
`ifdef PIPELINED_ADDER_SAT_EN
    sat_d = '0;
`endif
    for (int k = 0; k < LAST; k++) begin
      a_d[k] = src_a[k];
      b_d[k] = src_b[k];
`ifdef PIPELINED_ADDER_SAT_EN
      sat_d[k] = src_sat[k];
`endif
    end

    // Overflow and carry always describe the unclamped result.
    raw_s = sum_d[LAST];
    ovf_d = (src_a[LAST][MSB] == src_b[LAST][MSB]) && (raw_s[MSB] != src_a[LAST][MSB]);
`ifdef PIPELINED_ADDER_SAT_EN
    smin = WIDTH'(1) << MSB;
    if (src_sat[LAST] && ovf_d) begin
      sum_d[LAST] = src_a[LAST][MSB] ? smin : ~smin;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      carry_q <= '0;
      sum_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      ovf_q   <= 1'b0;
`ifdef PIPELINED_ADDER_SAT_EN
      sat_q   <= '0;
`endif
    end else if (adv) begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ovf_q   <= ovf_d;
`ifdef PIPELINED_ADDER_SAT_EN
      sat_q   <= sat_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`timescale 1ns/1ps
`default_nettype none
// tb_pipelined_adder: directed vector table, stream/stall, mid-operation reset and random parameter sweep.
module tb_pipelined_adder;

`ifdef PIPELINED_ADDER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam int NSW = 1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, in_ready, cin, sub, sat, out_valid, out_ready, cout, ovf;
  logic [15:0] a, b, s;

  logic        sw_valid, sw_cin, sw_sub;
  logic [31:0] sw_a, sw_b;
  logic        r4, v4, c4, o4, r8, v8, c8, o8, r32, v32, c32, o32;
  logic [3:0]  s4;
  logic [7:0]  s8;
  logic [31:0] s32;

  pipelined_adder #(.WIDTH(16), .SEG(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
`ifdef PIPELINED_ADDER_SAT_EN
    .sat(sat),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .s(s), .cout(cout), .ovf(ovf));

  pipelined_adder #(.WIDTH(4), .SEG(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(r4),
    .a(sw_a[3:0]), .b(sw_b[3:0]), .cin(sw_cin), .sub(sw_sub),
`ifdef PIPELINED_ADDER_SAT_EN
    .sat(1'b0),
`endif
    .out_valid(v4), .out_ready(1'b1), .s(s4), .cout(c4), .ovf(o4));

  pipelined_adder #(.WIDTH(8), .SEG(2)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(r8),
    .a(sw_a[7:0]), .b(sw_b[7:0]), .cin(sw_cin), .sub(sw_sub),
`ifdef PIPELINED_ADDER_SAT_EN
    .sat(1'b0),
`endif
    .out_valid(v8), .out_ready(1'b1), .s(s8), .cout(c8), .ovf(o8));

  pipelined_adder #(.WIDTH(32), .SEG(8)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(r32),
    .a(sw_a), .b(sw_b), .cin(sw_cin), .sub(sw_sub),
`ifdef PIPELINED_ADDER_SAT_EN
    .sat(1'b0),
`endif
    .out_valid(v32), .out_ready(1'b1), .s(s32), .cout(c32), .ovf(o32));

  typedef struct {
    logic [15:0] a, b;
    logic        cin, sub, sat;
    logic [15:0] s;
    logic        cout, ovf;
  } vec_t;

  vec_t vecs[10];
  vec_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  logic [33:0] e4[NSW], e8[NSW], e32[NSW];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Independent reference: {ovf, cout, s} for a w-bit add/subtract.
  function automatic logic [33:0] model(input int w, input logic [31:0] x, input logic [31:0] y,
                                        input logic ci, input logic su);
    logic [63:0] mask, av, bv, sum;
    logic        co, ov;
    mask = (64'd1 << w) - 64'd1;
    av   = {32'd0, x} & mask;
    bv   = (su ? ~{32'd0, y} : {32'd0, y}) & mask;
    sum  = av + bv + {63'd0, ci ^ su};
    co   = sum[w];
    ov   = (av[w-1] == bv[w-1]) && (sum[w-1] != av[w-1]);
    return {ov, co, sum[31:0] & mask[31:0]};
  endfunction

  task automatic drive(input vec_t v);
    a = v.a; b = v.b; cin = v.cin; sub = v.sub; sat = v.sat;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, issued, retired, drop, stall, extra, stale;
    vec_t v;

    vecs[0] = '{16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h0007, 16'h0005, 1'b0, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0};
    vecs[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, SAT ? 16'h8000 : 16'h7FFF, 1'b1, 1'b1};
    vecs[6] = '{16'h0010, 16'h0003, 1'b1, 1'b1, 1'b0, 16'h000C, 1'b1, 1'b0};
    vecs[7] = '{16'h00FF, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[8] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[9] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0; sat = 1'b0;
    sw_valid = 1'b0; sw_a = '0; sw_b = '0; sw_cin = 1'b0; sw_sub = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_s", s, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;

    // Directed table: one operation at a time, latency counted from the accepting edge.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
        @(posedge clk);
        #1 lat++;
      end
      check($sformatf("vec%0d_latency", i), lat, 4);
      check($sformatf("vec%0d_s", i), s, vecs[i].s);
      check($sformatf("vec%0d_cout", i), cout, vecs[i].cout);
      check($sformatf("vec%0d_ovf", i), ovf, vecs[i].ovf);
    end

    // Back-to-back stream of 8, consumer stalls 3 cycles after the first result.
    @(negedge clk);
    issued = 0; retired = 0; drop = 0; stall = 0;
    for (int cyc = 0; cyc < 60 && retired < 8; cyc++) begin
      @(negedge clk);
      out_ready = (drop == 0);
      if (drop > 0) drop--;
      in_valid = (issued < 8);
      if (issued < 8) drive(vecs[issued]);
      #1;
      if (!in_ready) stall++;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("stream_unexpected_result", 1, 0);
        end else if (!out_ready) begin
          check("stall_hold_s", s, exp_q[0].s);
        end else begin
          v = exp_q.pop_front();
          check($sformatf("stream%0d", retired), {cout, ovf, s}, {v.cout, v.ovf, v.s});
          retired++;
          if (retired == 1) drop = 3;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(vecs[issued]);
        issued++;
      end
    end
    check("stream_retired", retired, 8);
    check("stream_stall_cycles", stall, 3);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    check("stream_no_duplicate", extra, 0);

    // Reset with three operations in flight.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_s", s, 0);
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("midrst_no_stale", stale, 0);

    // Random sweep over three geometries; latency 1, 4 and 4 respectively.
    for (int j = 0; j < NSW + 8; j++) begin
      @(negedge clk);
      if (j >= 1 && j - 1 < NSW)
        check("sweep_4_4", {v4, o4, c4, 28'd0, s4}, {1'b1, e4[j-1]});
      else
        check("sweep_4_4_idle", v4, 0);
      if (j >= 4 && j - 4 < NSW) begin
        check("sweep_8_2", {v8, o8, c8, 24'd0, s8}, {1'b1, e8[j-4]});
        check("sweep_32_8", {v32, o32, c32, s32}, {1'b1, e32[j-4]});
      end else begin
        check("sweep_8_2_idle", v8, 0);
        check("sweep_32_8_idle", v32, 0);
      end
      if (j < NSW) begin
        sw_valid = 1'b1;
        sw_a     = $urandom;
        sw_b     = $urandom;
        sw_cin   = 1'($urandom_range(1));
        sw_sub   = 1'($urandom_range(1));
        e4[j]    = model(4, sw_a, sw_b, sw_cin, sw_sub);
        e8[j]    = model(8, sw_a, sw_b, sw_cin, sw_sub);
        e32[j]   = model(32, sw_a, sw_b, sw_cin, sw_sub);
      end else begin
        sw_valid = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
